// File: rtl/program_loader.sv
// Program loader: receives a byte stream (2-byte word count, then 4-byte
// little-endian words), writes each word to program memory, and holds the
// CPU in reset until the image is complete.
// Optional feature macro LOADER_CHECKSUM_EN: after the last word a single
// XOR checksum byte is accepted and verified before DONE is entered.
`timescale 1ns/1ps

module program_loader #(
   parameter int                    MEMORY_DEPTH = 'h200,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  WriteEnable,
   output logic [DATA_WIDTH-1:0] WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  CpuHold,
   output logic                  Done,
   output logic                  Error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      WRITE,
      DONE,
      ERROR
`ifdef LOADER_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [15:0] word_count;
   logic [15:0] word_index;
   logic [1:0]  byte_index;
   logic [15:0] length_full;
   logic        length_bad;
   logic        last_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  checksum;
`endif

   // The high length byte arrives in LEN1 while the low byte is already stored,
   // so the full count is judged combinationally on the accepting edge.
   assign length_full = {ByteIn, word_count[7:0]};
   assign length_bad  = (length_full == 16'd0) || (32'(length_full) > MEMORY_DEPTH);
   assign last_word   = ((word_index + 16'd1) == word_count);

   // State register; reset always returns the loader to IDLE.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state decode and state-derived outputs; reset forces safe output values.
   always_comb begin
      next_state  = state;
      ByteReady   = 1'b0;
      WriteEnable = 1'b0;
      CpuHold     = 1'b1;
      Done        = 1'b0;
      Error       = 1'b0;
      case (state)
         IDLE: begin
            if (Start)
               next_state = LEN0;
         end
         LEN0: begin
            ByteReady = 1'b1;
            if (ByteValid)
               next_state = LEN1;
         end
         LEN1: begin
            ByteReady = 1'b1;
            if (ByteValid)
               next_state = length_bad ? ERROR : DATA;
         end
         DATA: begin
            ByteReady = 1'b1;
            if (ByteValid && (byte_index == 2'd3))
               next_state = WRITE;
         end
         WRITE: begin
            WriteEnable = 1'b1;
            if (last_word)
`ifdef LOADER_CHECKSUM_EN
               next_state = CHECK;
`else
               next_state = DONE;
`endif
            else
               next_state = DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            ByteReady = 1'b1;
            if (ByteValid)
               next_state = (ByteIn == checksum) ? DONE : ERROR;
         end
`endif
         DONE: begin
            CpuHold = 1'b0;
            Done    = 1'b1;
            if (Start)
               next_state = LEN0;
         end
         ERROR: begin
            Error = 1'b1;
            if (Start)
               next_state = LEN0;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (reset) begin
         ByteReady   = 1'b0;
         WriteEnable = 1'b0;
         CpuHold     = 1'b1;
         Done        = 1'b0;
         Error       = 1'b0;
      end
   end

   // Datapath: length capture, word assembly, address generation and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_count   <= 16'd0;
         word_index   <= 16'd0;
         byte_index   <= 2'd0;
         WriteAddress <= '0;
         WriteData    <= '0;
`ifdef LOADER_CHECKSUM_EN
         checksum     <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (Start) begin
                  word_count <= 16'd0;
                  word_index <= 16'd0;
                  byte_index <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  checksum   <= 8'd0;
`endif
               end
            end
            LEN0: begin
               if (ByteValid)
                  word_count[7:0] <= ByteIn;
            end
            LEN1: begin
               if (ByteValid)
                  word_count[15:8] <= ByteIn;
            end
            DATA: begin
               if (ByteValid) begin
                  WriteData[8*byte_index +: 8] <= ByteIn;
                  byte_index <= byte_index + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  checksum   <= checksum ^ ByteIn;
`endif
                  if (byte_index == 2'd3)
                     WriteAddress <= BASE_ADDRESS + DATA_WIDTH'({word_index, 2'b00});
               end
            end
            WRITE: begin
               word_index <= word_index + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
`timescale 1ns/1ps

module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        WriteEnable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic        CpuHold;
   logic        Done;
   logic        Error;

   int          total_checks  = 0;
   int          passed_checks = 0;
   int          ready_in_write = 0;
   int          log_mark;
   logic [31:0] addr_log[$];
   logic [31:0] data_log[$];
   logic [7:0]  csum;

   program_loader dut (
      .clk          (clk),
      .reset        (reset),
      .Start        (Start),
      .ByteIn       (ByteIn),
      .ByteValid    (ByteValid),
      .ByteReady    (ByteReady),
      .WriteEnable  (WriteEnable),
      .WriteAddress (WriteAddress),
      .WriteData    (WriteData),
      .CpuHold      (CpuHold),
      .Done         (Done),
      .Error        (Error)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Record every write strobe mid-cycle, and note any overlap with ByteReady.
   always @(negedge clk) begin
      if (WriteEnable === 1'b1) begin
         addr_log.push_back(WriteAddress);
         data_log.push_back(WriteData);
         if (ByteReady !== 1'b0)
            ready_in_write++;
      end
   end

   // Hard stop in case the bench itself wedges.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      assert (observed === expected) passed_checks = passed_checks + 1;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and hold it until the loader accepts it.
   task automatic apply_stimulus(input logic [7:0] b);
      int waited = 0;
      ByteIn    = b;
      ByteValid = 1'b1;
      while (ByteReady !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50)
         check_output("byte_accept_timeout", 32'(waited), 32'd0);
      tick();
      ByteValid = 1'b0;
   endtask

   task automatic idle(input int n);
      ByteValid = 1'b0;
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic start_session();
      csum  = 8'h00;
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic send_length(input logic [15:0] n);
      apply_stimulus(n[7:0]);
      apply_stimulus(n[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(w[8*k +: 8]);
         csum = csum ^ w[8*k +: 8];
         if (gap > 0 && k < 3)
            idle(gap);
      end
   endtask

   // Step from the last WRITE cycle into DONE (through CHECK when enabled).
   task automatic finish_session();
`ifdef LOADER_CHECKSUM_EN
      apply_stimulus(csum);
`else
      tick();
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_ready"}, 32'(ByteReady), 32'd0);
      check_output({tag, "_we"},    32'(WriteEnable), 32'd0);
      check_output({tag, "_addr"},  WriteAddress, 32'h0);
      check_output({tag, "_data"},  WriteData, 32'h0);
      check_output({tag, "_done"},  32'(Done), 32'd0);
      check_output({tag, "_error"}, 32'(Error), 32'd0);
      check_output({tag, "_hold"},  32'(CpuHold), 32'd1);
   endtask

   // Directed sequence covering reset, normal loads, length errors, full depth and mid-session reset.
   initial begin
      reset     = 1'b1;
      Start     = 1'b0;
      ByteIn    = 8'h00;
      ByteValid = 1'b0;
      csum      = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      check_reset_outputs("reset");

      // Single-word load
      start_session();
      check_output("len0_ready", 32'(ByteReady), 32'd1);
      send_length(16'd1);
      send_word(32'h1234_5678, 0);
      check_output("n1_we",    32'(WriteEnable), 32'd1);
      check_output("n1_ready", 32'(ByteReady), 32'd0);
      check_output("n1_addr",  WriteAddress, 32'h0040_0000);
      check_output("n1_data",  WriteData, 32'h1234_5678);
      finish_session();
      check_output("n1_done",   32'(Done), 32'd1);
      check_output("n1_hold",   32'(CpuHold), 32'd0);
      check_output("n1_error",  32'(Error), 32'd0);
      check_output("n1_writes", 32'(addr_log.size()), 32'd1);

      // Three words with ByteValid toggling, plus an ignored Start mid-session
      start_session();
      check_output("restart_done", 32'(Done), 32'd0);
      log_mark = addr_log.size();
      send_length(16'd3);
      send_word(32'hA3A2_A1A0, 1);
      idle(1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check_output("start_ignored_ready", 32'(ByteReady), 32'd1);
      send_word(32'hB3B2_B1B0, 1);
      idle(1);
      send_word(32'hC3C2_C1C0, 1);
      finish_session();
      check_output("n3_done",   32'(Done), 32'd1);
      check_output("n3_writes", 32'(addr_log.size() - log_mark), 32'd3);
      if (addr_log.size() == log_mark + 3) begin
         check_output("n3_addr0", addr_log[log_mark],     32'h0040_0000);
         check_output("n3_addr1", addr_log[log_mark + 1], 32'h0040_0004);
         check_output("n3_addr2", addr_log[log_mark + 2], 32'h0040_0008);
         check_output("n3_data0", data_log[log_mark],     32'hA3A2_A1A0);
         check_output("n3_data1", data_log[log_mark + 1], 32'hB3B2_B1B0);
         check_output("n3_data2", data_log[log_mark + 2], 32'hC3C2_C1C0);
      end
      check_output("ready_in_write", 32'(ready_in_write), 32'd0);

      // Zero length and oversize length both abort
      log_mark = addr_log.size();
      start_session();
      send_length(16'd0);
      check_output("n0_error", 32'(Error), 32'd1);
      check_output("n0_hold",  32'(CpuHold), 32'd1);
      check_output("n0_ready", 32'(ByteReady), 32'd0);
      start_session();
      check_output("n0_clear", 32'(Error), 32'd0);
      check_output("n0_len0",  32'(ByteReady), 32'd1);
      send_length(16'h0201);
      check_output("nbig_error", 32'(Error), 32'd1);
      check_output("nbig_done",  32'(Done), 32'd0);
      check_output("err_writes", 32'(addr_log.size() - log_mark), 32'd0);

      // Full-depth image
      start_session();
      check_output("nmax_clear", 32'(Error), 32'd0);
      log_mark = addr_log.size();
      send_length(16'h0200);
      for (int i = 0; i < 'h200; i++)
         send_word(32'hC0DE_0000 + 32'(i), 0);
      finish_session();
      check_output("nmax_writes", 32'(addr_log.size() - log_mark), 32'd512);
      check_output("nmax_last_addr", addr_log[$], 32'h0040_07FC);
      check_output("nmax_last_data", data_log[$], 32'hC0DE_01FF);
      check_output("nmax_done", 32'(Done), 32'd1);

      // Reset in the middle of word 1
      start_session();
      send_length(16'd2);
      send_word(32'h1111_1111, 0);
      apply_stimulus(8'h22);
      apply_stimulus(8'h33);
      log_mark = addr_log.size();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("midreset");
      tick();
      check_output("midreset_no_we", 32'(addr_log.size() - log_mark), 32'd0);
      check_output("midreset_idle_ready", 32'(ByteReady), 32'd0);
      start_session();
      send_length(16'd1);
      send_word(32'hAABB_CCDD, 0);
      check_output("fresh_addr", WriteAddress, 32'h0040_0000);
      check_output("fresh_data", WriteData, 32'hAABB_CCDD);
      finish_session();
      check_output("fresh_done", 32'(Done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      // Checksum accept and reject
      start_session();
      send_length(16'd1);
      send_word(32'h0804_0201, 0);
      apply_stimulus(8'h0F);
      check_output("csum_ok_done", 32'(Done), 32'd1);
      start_session();
      send_length(16'd1);
      send_word(32'h0804_0201, 0);
      apply_stimulus(8'h0E);
      check_output("csum_bad_error", 32'(Error), 32'd1);
      check_output("csum_bad_hold",  32'(CpuHold), 32'd1);
`endif

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 'h200, program-memory depth in 32-bit words.
REQ-002 Parameter DATA_WIDTH, default 32, instruction/address width.
REQ-003 Parameter BASE_ADDRESS, default 32'h0040_0000, byte address of program-memory word 0.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  begin a load session; sampled only in IDLE, DONE, ERROR.
REQ-007 ByteIn  input  8  incoming stream byte.
REQ-008 ByteValid  input  1  ByteIn valid this cycle.
REQ-009 ByteReady  output  1  loader accepts a byte; transfer when ByteValid&&ByteReady at rising edge.
REQ-010 WriteEnable  output  1  one-cycle write strobe to program-memory write port.
REQ-011 WriteAddress  output  DATA_WIDTH  byte address of the word written.
REQ-012 WriteData  output  DATA_WIDTH  assembled instruction word.
REQ-013 CpuHold  output  1  holds processor PC/fetch in reset while high.
REQ-014 Done  output  1  load completed successfully; level.
REQ-015 Error  output  1  load aborted; level.

Function
REQ-016 Stream format: 2-byte word count N (LSB first), then N words of 4 bytes each, LSB first.
REQ-017 States: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR; encoding free.
REQ-018 IDLE -> LEN0 on Start; DONE or ERROR -> LEN0 on Start, clearing Done, Error, word index, byte index.
REQ-019 ByteReady high only in LEN0, LEN1, DATA; low in all other states, including the WRITE cycle.
REQ-020 LEN0 captures N[7:0], LEN1 captures N[15:8], each on an accepted byte; ByteValid low -> remain in state.
REQ-021 On LEN1 acceptance: N==0 or N>MEMORY_DEPTH -> ERROR; otherwise -> DATA.
REQ-022 DATA: accepted byte k (0..3) goes to WriteData[8k+7:8k]; on 4th byte -> WRITE.
REQ-023 WRITE lasts exactly one cycle: WriteEnable=1, WriteAddress=BASE_ADDRESS+4*index, WriteData stable.
REQ-024 After WRITE: index+1; index+1==N -> DONE (or checksum step, REQ-032), else -> DATA.
REQ-025 Byte-to-write latency: 1 cycle after 4th byte accepted; peak throughput 4 bytes per 5 cycles.
REQ-026 WriteEnable is 0 in every state except WRITE; WriteAddress/WriteData hold last values otherwise.
REQ-027 Index counter is 16 bits; no wrap possible since N<=MEMORY_DEPTH is enforced.
REQ-028 CpuHold=1 in all states except DONE; Done=1 only in DONE; Error=1 only in ERROR.
REQ-029 Start while in LEN0..WRITE is ignored; session is not restarted.

Reset
REQ-030 reset wins over every other input: next state IDLE; ByteReady=0, WriteEnable=0, WriteAddress=0, WriteData=0, Done=0, Error=0, CpuHold=1; counters and N cleared.
REQ-031 reset mid-session (any state, including WRITE) discards partial word; no WriteEnable in the cycle after reset.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: after last WRITE enter CHECK state, ByteReady=1, accept one byte; equal to XOR of all 4*N data bytes -> DONE, else -> ERROR. Already-written words are not retracted.
REQ-033 LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum logic; last WRITE -> DONE directly.

Verification
REQ-034 Start, N=1, bytes 78 56 34 12 -> one WriteEnable pulse, WriteAddress=32'h0040_0000, WriteData=32'h1234_5678, then Done=1, CpuHold=0.
REQ-035 N=3, ByteValid toggling every other cycle -> three writes at 0x0040_0000/04/08, no write while ByteValid low, ByteReady=0 in each WRITE cycle.
REQ-036 N=0 and N=MEMORY_DEPTH+1 -> ERROR after 2nd length byte, Error=1, CpuHold=1, WriteEnable never asserted; Start -> Error clears, LEN0.
REQ-037 N=MEMORY_DEPTH -> last write at 0x0040_0000+4*(MEMORY_DEPTH-1) (0x0040_07FC at default), then Done=1.
REQ-038 reset asserted after 2 bytes of word 1 -> IDLE, outputs at reset values, next session writes word 0 at 0x0040_0000 with fresh data.
REQ-039 LOADER_CHECKSUM_EN: N=1, data 01 02 04 08, checksum 0F -> Done=1; checksum 0E -> Error=1, CpuHold=1.
